// File: rtl/apb_gpi_irq.sv
// APB-attached general-purpose input block: per-pin synchronizers, enable/readback,
// rising/falling edge detection into a write-1-to-clear status register with a level interrupt.
module apb_gpi_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [4:0]       PADDR,
  input  logic             PWRITE,
  input  logic             PENABLE,
  input  logic             PSEL,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  input  logic [WIDTH-1:0] gpi,
  output logic             irq
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam logic [2:0] SEL_CR  = 3'd0;
  localparam logic [2:0] SEL_IDR = 3'd1;
  localparam logic [2:0] SEL_RER = 3'd2;
  localparam logic [2:0] SEL_FER = 3'd3;
  localparam logic [2:0] SEL_ISR = 3'd4;

  state_t           state;
  logic [WIDTH-1:0] cr;
  logic [WIDTH-1:0] rer;
  logic [WIDTH-1:0] fer;
  logic [WIDTH-1:0] isr;
  logic [WIDTH-1:0] sync_pipe [SYNC_STAGES];
  logic [WIDTH-1:0] sync_cur;
  logic [WIDTH-1:0] sync_prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] isr_set;
  logic [WIDTH-1:0] isr_clr;
  logic [WIDTH-1:0] wdata;
  logic [2:0]       reg_sel;
  logic             access;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      rdata_mux;
  logic             unused_apb;

  // Registers narrower than the bus read back with zero upper bits.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign unused_apb = ^{PADDR[1:0], PWDATA};

  assign reg_sel = PADDR[4:2];
  assign wdata   = PWDATA[WIDTH-1:0];
  // Only the first PSEL&&PENABLE sample in IDLE commits; the ACK cycle is ignored.
  assign access  = (state == IDLE) && PSEL && PENABLE;
  assign wr_en   = access && PWRITE;
  assign rd_en   = access && !PWRITE;

  // ---- input synchronizer stages ----
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '0;
      sync_prev <= '0;
    end else begin
      sync_pipe[0] <= gpi;
      for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
      sync_prev <= sync_cur;
    end
  end

  assign sync_cur = sync_pipe[SYNC_STAGES-1];
  assign rise     = sync_cur & ~sync_prev;
  assign fall     = ~sync_cur & sync_prev;
  assign isr_set  = (rise & cr & rer) | (fall & cr & fer);
  assign isr_clr  = (wr_en && reg_sel == SEL_ISR) ? wdata : '0;

  // ---- status register: a new event wins over a same-edge clear ----
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      isr <= '0;
    end else begin
      isr <= (isr & ~isr_clr) | isr_set;
    end
  end

  assign irq = |isr;

  always_comb begin
    rdata_mux = '0;
    case (reg_sel)
      SEL_CR:  rdata_mux = zext(cr);
      SEL_IDR: rdata_mux = zext(sync_cur & cr);
      SEL_RER: rdata_mux = zext(rer);
      SEL_FER: rdata_mux = zext(fer);
      SEL_ISR: rdata_mux = zext(isr);
      default: rdata_mux = '0;
    endcase
  end

  // ---- APB transfer FSM and control registers ----
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state  <= IDLE;
      PREADY <= 1'b0;
      PRDATA <= '0;
      cr     <= '0;
      rer    <= '0;
      fer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state  <= ACK;
            PREADY <= 1'b1;
          end
        end
        ACK: begin
          state  <= IDLE;
          PREADY <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          PREADY <= 1'b0;
        end
      endcase
      if (rd_en) PRDATA <= rdata_mux;
      if (wr_en) begin
        case (reg_sel)
          SEL_CR:  cr  <= wdata;
          SEL_RER: rer <= wdata;
          SEL_FER: fer <= wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_gpi_irq.sv
// Directed bench for apb_gpi_irq: register access, synchronizer latency, edge
// events, clear/set collision, unmapped offsets and reset during a transfer.
module tb_apb_gpi_irq;

  localparam int W = 8;
  localparam int S = 2;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic [4:0]   PADDR;
  logic         PWRITE;
  logic         PENABLE;
  logic         PSEL;
  logic [31:0]  PWDATA;
  logic [31:0]  PRDATA;
  logic         PREADY;
  logic [W-1:0] gpi;
  logic         irq;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rd;

  apb_gpi_irq #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .gpi(gpi), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Caller is just after a negedge: setup phase now, access phase one cycle later.
  task automatic apb_start(input logic wr, input logic [4:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PWRITE = wr; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
  endtask

  // Waits (bounded) for PREADY, keeps the request asserted across the ACK edge,
  // then checks PREADY has dropped after exactly one cycle.
  task automatic apb_finish(input string tag, output logic [31:0] rdata);
    int n;
    n = 0;
    while (PREADY !== 1'b1 && n < 8) begin
      @(negedge PCLK);
      n++;
    end
    chk({tag, "_pready_hi"}, {31'b0, PREADY}, 32'd1);
    rdata = PRDATA;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk({tag, "_pready_lo"}, {31'b0, PREADY}, 32'd0);
  endtask

  task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                          input string tag, output logic [31:0] rdata);
    @(negedge PCLK);
    apb_start(wr, addr, data);
    apb_finish(tag, rdata);
  endtask

  task automatic apb_write(input logic [4:0] addr, input logic [31:0] data, input string tag);
    logic [31:0] dummy;
    apb_xfer(1'b1, addr, data, tag, dummy);
  endtask

  task automatic apb_read(input logic [4:0] addr, input string tag, input logic [31:0] exp);
    logic [31:0] r;
    apb_xfer(1'b0, addr, 32'h0, tag, r);
    chk(tag, r, exp);
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; gpi = '0; rd = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_pready", {31'b0, PREADY}, 32'd0);
    chk("rst_irq",    {31'b0, irq},    32'd0);
    chk("rst_prdata", PRDATA,          32'd0);
    PRESET = 1'b0;
    apb_read(5'h00, "rst_cr", 32'h0);

    // Enabled pins reflect synchronized input.
    apb_write(5'h00, 32'hFF, "wr_cr_ff");
    gpi = 8'hA5;
    repeat (3) @(negedge PCLK);
    apb_read(5'h04, "idr_a5", 32'h000000A5);

    // Disabled pins read 0.
    apb_write(5'h00, 32'h0F, "wr_cr_0f");
    gpi = 8'hFF;
    repeat (3) @(negedge PCLK);
    apb_read(5'h04, "idr_0f", 32'h0000000F);
    apb_read(5'h10, "isr_none", 32'h0);

    // Rising event latency: status appears S+1 edges after the pin change.
    gpi = 8'h00;
    repeat (5) @(negedge PCLK);
    apb_write(5'h00, 32'h01, "wr_cr_01");
    apb_write(5'h08, 32'h01, "wr_rer_01");
    @(negedge PCLK);
    gpi = 8'h01;
    repeat (S) @(posedge PCLK);
    #1;
    chk("irq_before_latency", {31'b0, irq}, 32'd0);
    @(posedge PCLK);
    #1;
    chk("irq_at_latency", {31'b0, irq}, 32'd1);
    apb_read(5'h10, "isr_rise", 32'h01);
    apb_write(5'h10, 32'h01, "w1c_isr_01");
    chk("irq_after_w1c", {31'b0, irq}, 32'd0);
    apb_read(5'h10, "isr_cleared", 32'h0);

    // Falling event on bit 1, then a second fall colliding with a W1C.
    apb_write(5'h00, 32'h02, "wr_cr_02");
    apb_write(5'h0C, 32'h02, "wr_fer_02");
    gpi = 8'h03;
    repeat (5) @(negedge PCLK);
    gpi = 8'h01;
    repeat (5) @(negedge PCLK);
    apb_read(5'h10, "isr_fall", 32'h02);
    gpi = 8'h03;
    repeat (5) @(negedge PCLK);
    gpi = 8'h01;
    repeat (S - 1) @(negedge PCLK);
    apb_start(1'b1, 5'h10, 32'h02);
    apb_finish("w1c_collide", rd);
    apb_read(5'h10, "isr_set_wins", 32'h02);
    chk("irq_set_wins", {31'b0, irq}, 32'd1);

    // Disabling a pin leaves its pending status intact.
    apb_write(5'h00, 32'h00, "wr_cr_00");
    apb_read(5'h10, "isr_kept_cr0", 32'h02);
    apb_read(5'h18, "unmapped_18", 32'h0);
    apb_write(5'h10, 32'h02, "w1c_isr_02");
    apb_read(5'h10, "isr_clear2", 32'h0);

    // IDR is read-only.
    apb_write(5'h00, 32'h02, "wr_cr_02b");
    gpi = 8'h03;
    repeat (5) @(negedge PCLK);
    apb_write(5'h04, 32'hFF, "wr_idr");
    apb_read(5'h04, "idr_ro", 32'h02);
    apb_read(5'h00, "cr_unchanged", 32'h02);

    // Reset during the ACK cycle of a CR write.
    gpi = 8'h01;
    repeat (5) @(negedge PCLK);
    apb_read(5'h10, "isr_pre_rst", 32'h02);
    chk("irq_pre_rst", {31'b0, irq}, 32'd1);
    @(negedge PCLK);
    apb_start(1'b1, 5'h00, 32'h55);
    @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    #1;
    chk("midrst_pready", {31'b0, PREADY}, 32'd0);
    chk("midrst_irq",    {31'b0, irq},    32'd0);
    chk("midrst_prdata", PRDATA,          32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    apb_read(5'h00, "cr_after_rst", 32'h0);

    // Pin held high through reset with CR=0 raises nothing.
    repeat (5) @(negedge PCLK);
    chk("irq_held_high_cr0", {31'b0, irq}, 32'd0);
    apb_read(5'h10, "isr_after_rst", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
